// File: rtl/seq_pkg.sv
// Shared constants and sizing helpers for the serial-to-parallel datapath.
package seq_pkg;

    localparam int MSB_FIRST_MODE = 1;
    localparam int LSB_FIRST_MODE = 0;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int cnt_max(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/dff_r.sv
// Single-bit rising-edge flop with asynchronous active-low reset to zero.
module dff_r (
    input  logic c,
    input  logic rn,
    input  logic d,
    output logic Q,
    output logic Qn
);

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            Q <= 1'b0;
        end else begin
            Q <= d;
        end
    end

    assign Qn = ~Q;

endmodule

// File: rtl/sipo_shift_register.sv
// Serial-in parallel-out shift register with frame counter and word capture.
module sipo_shift_register
    import seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    localparam int CW       = clog2(WIDTH)
) (
    input  logic             c,
    input  logic             rn,
    input  logic             d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int            CNT_MAX = cnt_max(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] word_nx;
    logic [CW-1:0]    cnt_nx;
    logic             done_nx;
    logic [WIDTH-1:0] shifted;
    logic             wrap;

    assign wrap = (cnt == CNT_TOP);

    always_comb begin
        if (MSB_FIRST == MSB_FIRST_MODE) begin
            shifted = {q[WIDTH-2:0], d};
        end else begin
            shifted = {d, q[WIDTH-1:1]};
        end
    end

    // clr wins over en; word is only touched on a completed frame.
    always_comb begin
        q_nx    = q;
        cnt_nx  = cnt;
        word_nx = word;
        done_nx = 1'b0;
        if (clr) begin
            q_nx   = '0;
            cnt_nx = '0;
        end else if (en) begin
            q_nx = shifted;
            if (wrap) begin
                cnt_nx  = '0;
                word_nx = shifted;
                done_nx = 1'b1;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_data
        dff_r u_q (
            .c (c),
            .rn(rn),
            .d (q_nx[i]),
            .Q (q[i]),
            .Qn()
        );
        dff_r u_word (
            .c (c),
            .rn(rn),
            .d (word_nx[i]),
            .Q (word[i]),
            .Qn()
        );
    end

    for (genvar i = 0; i < CW; i++) begin : g_cnt
        dff_r u_cnt (
            .c (c),
            .rn(rn),
            .d (cnt_nx[i]),
            .Q (cnt[i]),
            .Qn()
        );
    end

    dff_r u_done (
        .c (c),
        .rn(rn),
        .d (done_nx),
        .Q (done),
        .Qn()
    );

endmodule

// File: tb/tb_sipo_shift_register.sv
// Scoreboard bench: stimulus queues expected words, a monitor checks them on done.
module tb_sipo_shift_register;

    logic       c = 1'b0;
    logic       rn = 1'b0;
    logic       d = 1'b0;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] q_a, q_b, word_a, word_b;
    logic [1:0] cnt_a, cnt_b;
    logic       done_a, done_b;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always #5 c = ~c;

    sipo_shift_register #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
        .c(c), .rn(rn), .d(d), .en(en_a), .clr(clr),
        .q(q_a), .cnt(cnt_a), .word(word_a), .done(done_a)
    );

    sipo_shift_register #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
        .c(c), .rn(rn), .d(d), .en(en_b), .clr(clr),
        .q(q_b), .cnt(cnt_b), .word(word_b), .done(done_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic bit_d, input logic ea, input logic eb,
                        input logic cl);
        @(negedge c);
        d = bit_d;
        en_a = ea;
        en_b = eb;
        clr = cl;
        @(posedge c);
        #1;
    endtask

    task automatic send_a(input logic [3:0] bits, input logic [3:0] exp_word);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) exp_a.push_back(exp_word);
            step(bits[i], 1'b1, 1'b0, 1'b0);
        end
    endtask

    always @(negedge c) begin
        if (rn) begin
            if (done_a) begin
                if (exp_a.size() == 0) check("a_extra_done", 1, 0);
                else check("a_word", int'(word_a), int'(exp_a.pop_front()));
                check("a_done_gap", int'(prev_a), 0);
            end
            if (done_b) begin
                if (exp_b.size() == 0) check("b_extra_done", 1, 0);
                else check("b_word", int'(word_b), int'(exp_b.pop_front()));
                check("b_done_gap", int'(prev_b), 0);
            end
            prev_a = done_a;
            prev_b = done_b;
        end else begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end
    end

    initial begin
        #3;
        check("rst_q", int'(q_a), 0);
        check("rst_cnt", int'(cnt_a), 0);
        check("rst_word", int'(word_a), 0);
        check("rst_done", int'(done_a), 0);
        @(negedge c);
        rn = 1'b1;

        // 1: plain frame
        send_a(4'b1011, 4'b1011);
        check("t1_q", int'(q_a), 4'b1011);
        check("t1_cnt", int'(cnt_a), 0);
        check("t1_done", int'(done_a), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_done_low", int'(done_a), 0);

        // 2: gap of two idle cycles between bits 2 and 3
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_gap_cnt", int'(cnt_a), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_gap_cnt2", int'(cnt_a), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        exp_a.push_back(4'b1011);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_q", int'(q_a), 4'b1011);

        // 3: clear a partial frame, en and d ignored on that edge
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_cnt_pre", int'(cnt_a), 2);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("t3_q", int'(q_a), 0);
        check("t3_cnt", int'(cnt_a), 0);
        check("t3_word", int'(word_a), 4'b1011);
        check("t3_done", int'(done_a), 0);
        send_a(4'b0110, 4'b0110);

        // 4: back-to-back frames
        send_a(4'b1001, 4'b1001);
        send_a(4'b0111, 4'b0111);

        // 5: asynchronous reset mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge c);
        en_a = 1'b0;
        rn = 1'b0;
        #1;
        check("t5_q", int'(q_a), 0);
        check("t5_cnt", int'(cnt_a), 0);
        check("t5_word", int'(word_a), 0);
        check("t5_done", int'(done_a), 0);
        #1;
        rn = 1'b1;
        send_a(4'b0011, 4'b0011);

        // 6: LSB-first instance
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        exp_b.push_back(4'b1101);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_q", int'(q_b), 4'b1101);
        check("t6_done", int'(done_b), 1);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("a_pending", exp_a.size(), 0);
        check("b_pending", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
